// File: rtl/psd_pkg.sv
// Shared float32 helpers and FSM state type for the power-spectrum peak capture block.
package psd_pkg;

  localparam int unsigned FP32_W   = 32;
  localparam int unsigned FP_EXP_W = 8;
  localparam logic [FP_EXP_W-1:0] FP_EXP_NAN = 8'hFF;

  typedef enum logic {
    CAPTURE = 1'b0,
    HOLD    = 1'b1
  } psd_state_e;

  function automatic logic fp_is_nan(input logic [FP32_W-1:0] v);
    return (v[30:23] == FP_EXP_NAN) && (v[22:0] != '0);
  endfunction

  // Magnitude compare on exponent+mantissa; sign ignored so -0 == +0.
  function automatic logic fp_mag_gt(input logic [FP32_W-1:0] a,
                                     input logic [FP32_W-1:0] b);
    return a[30:0] > b[30:0];
  endfunction

endpackage

// File: rtl/simple_dual_port_ram.sv
// One write port, one registered read port; read data holds when not enabled.
module simple_dual_port_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/power_spectrum_peak_capture.sv
// Captures one frame of float32 power bins into RAM, tracks the peak bin and
// presents the result over valid/ready; stored frame is readable while held.
module power_spectrum_peak_capture
  import psd_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pwr_data,
  input  logic              pwr_data_en,
  input  logic              pwr_data_last,
  output logic              peak_valid,
  input  logic              peak_ready,
  output logic [ADDR_W-1:0] peak_index,
  output logic [DATA_W-1:0] peak_value,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_ovf,
  output logic              frame_drop,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  psd_state_e        r_state;
  logic [ADDR_W:0]   r_len;
  logic              r_ovf;
  logic              r_pk_any;
  logic [ADDR_W-1:0] r_pk_idx;
  logic [DATA_W-1:0] r_pk_val;

  logic              w_beat;
  logic              w_full;
  logic              w_wr;
  logic              w_pk_upd;
  logic              w_ram_rd;
  logic [ADDR_W:0]   w_len_nxt;
  logic              w_ovf_nxt;
  logic [ADDR_W-1:0] w_pk_idx_nxt;
  logic [DATA_W-1:0] w_pk_val_nxt;

  assign w_beat   = (r_state == CAPTURE) && pwr_data_en;
  assign w_full   = r_len[ADDR_W];
  assign w_wr     = w_beat && !w_full;
  // Beats past capacity are not stored, so they cannot become the peak either.
  assign w_pk_upd = w_wr && !fp_is_nan(pwr_data) &&
                    (!r_pk_any || fp_mag_gt(pwr_data, r_pk_val));
  assign w_ram_rd = rd_en && (r_state == HOLD);

  // Next-state accumulators let a last coinciding with en include that beat.
  always_comb begin
    w_len_nxt    = r_len + (ADDR_W+1)'(w_wr);
    w_ovf_nxt    = r_ovf | (w_beat & w_full);
    w_pk_idx_nxt = r_pk_idx;
    w_pk_val_nxt = r_pk_val;
    if (w_pk_upd) begin
      w_pk_idx_nxt = r_len[ADDR_W-1:0];
      w_pk_val_nxt = pwr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CAPTURE;
      r_len      <= '0;
      r_ovf      <= 1'b0;
      r_pk_any   <= 1'b0;
      r_pk_idx   <= '0;
      r_pk_val   <= '0;
      peak_valid <= 1'b0;
      peak_index <= '0;
      peak_value <= '0;
      frame_len  <= '0;
      frame_ovf  <= 1'b0;
      frame_drop <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_drop <= 1'b0;
      case (r_state)
        CAPTURE: begin
          r_len    <= w_len_nxt;
          r_ovf    <= w_ovf_nxt;
          r_pk_any <= r_pk_any | w_pk_upd;
          r_pk_idx <= w_pk_idx_nxt;
          r_pk_val <= w_pk_val_nxt;
          busy     <= (w_len_nxt != '0) || pwr_data_last;
          if (pwr_data_last) begin
            peak_valid <= 1'b1;
            peak_index <= w_pk_idx_nxt;
            peak_value <= w_pk_val_nxt;
            frame_len  <= w_len_nxt;
            frame_ovf  <= w_ovf_nxt;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          frame_drop <= pwr_data_last;
          if (peak_valid && peak_ready) begin
            peak_valid <= 1'b0;
            busy       <= 1'b0;
            r_len      <= '0;
            r_ovf      <= 1'b0;
            r_pk_any   <= 1'b0;
            r_pk_idx   <= '0;
            r_pk_val   <= '0;
            r_state    <= CAPTURE;
          end
        end
        default: r_state <= CAPTURE;
      endcase
    end
  end

  simple_dual_port_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_len[ADDR_W-1:0]),
    .i_wr_data (pwr_data),
    .i_rd_en   (w_ram_rd),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

endmodule

// File: tb/tb_power_spectrum_peak_capture.sv
// Directed plus randomized check of power_spectrum_peak_capture (8-bin capacity).
module tb_power_spectrum_peak_capture;

  localparam int unsigned AW  = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] pwr_data;
  logic          pwr_data_en;
  logic          pwr_data_last;
  logic          peak_valid;
  logic          peak_ready;
  logic [AW-1:0] peak_index;
  logic [DW-1:0] peak_value;
  logic [AW:0]   frame_len;
  logic          frame_ovf;
  logic          frame_drop;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;

  power_spectrum_peak_capture #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .pwr_data(pwr_data), .pwr_data_en(pwr_data_en),
    .pwr_data_last(pwr_data_last), .peak_valid(peak_valid), .peak_ready(peak_ready),
    .peak_index(peak_index), .peak_value(peak_value), .frame_len(frame_len),
    .frame_ovf(frame_ovf), .frame_drop(frame_drop), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [31:0] frame_q[$];
  logic [31:0] m_mem [CAP];
  bit          m_ok  [CAP];
  logic [31:0] e_rd;
  logic [31:0] e_idx, e_val, e_len;
  logic        e_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
      1: v = 32'h7F800000;
      2: v = 32'h00000000;
      3: v = 32'h80000000;
      4, 5: v = {1'($urandom_range(0, 1)), 8'h40, 23'($urandom_range(0, 3)) << 20};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, peak_valid, 0);
    chk({tag, "_idx"},   peak_index, 0);
    chk({tag, "_val"},   peak_value, 0);
    chk({tag, "_len"},   frame_len, 0);
    chk({tag, "_ovf"},   frame_ovf, 0);
    chk({tag, "_drop"},  frame_drop, 0);
    chk({tag, "_rd"},    rd_data, 0);
    chk({tag, "_busy"},  busy, 0);
  endtask

  // Drives frame_q; last_gap 0 puts last on the final beat, else last comes last_gap cycles later.
  task automatic send_frame(input int unsigned last_gap, input bit gaps);
    int unsigned n = frame_q.size();
    int unsigned sent = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      pwr_data    = frame_q[i];
      pwr_data_en = 1'b1;
      if (i == n - 1 && last_gap == 0) begin
        chk("pre_last_valid", peak_valid, 0);
        chk("pre_last_busy", busy, 64'(sent > 0));
        pwr_data_last = 1'b1;
      end
      tick();
      pwr_data_en   = 1'b0;
      pwr_data_last = 1'b0;
      sent++;
    end
    if (n == 0 || last_gap != 0) begin
      if (last_gap > 0) repeat (last_gap - 1) tick();
      chk("pre_last_valid", peak_valid, 0);
      chk("pre_last_busy", busy, 64'(sent > 0));
      pwr_data_last = 1'b1;
      tick();
      pwr_data_last = 1'b0;
    end
  endtask

  // Reference: largest magnitude among stored non-NaN bins, earliest index on ties.
  task automatic check_result(input string tag);
    int unsigned n = frame_q.size();
    int unsigned stored = (n > CAP) ? CAP : n;
    logic [30:0] best = '0;
    bit found = 0;
    e_idx = 0;
    e_val = 0;
    for (int unsigned i = 0; i < stored; i++)
      if (!is_nan(frame_q[i]) && (!found || frame_q[i][30:0] > best)) begin
        best = frame_q[i][30:0];
        found = 1;
      end
    if (found)
      for (int i = int'(stored) - 1; i >= 0; i--)
        if (!is_nan(frame_q[i]) && frame_q[i][30:0] == best) begin
          e_idx = 32'(i);
          e_val = frame_q[i];
        end
    e_len = stored;
    e_ovf = n > CAP;
    for (int unsigned i = 0; i < stored; i++) begin
      m_mem[i] = frame_q[i];
      m_ok[i]  = 1;
    end
    chk({tag, "_valid"}, peak_valid, 1);
    chk({tag, "_idx"},   peak_index, e_idx);
    chk({tag, "_val"},   peak_value, e_val);
    chk({tag, "_len"},   frame_len, e_len);
    chk({tag, "_ovf"},   frame_ovf, e_ovf);
    chk({tag, "_busy"},  busy, 1);
  endtask

  task automatic readback_all(input string tag);
    for (int unsigned a = 0; a < CAP; a++) begin
      if (!m_ok[a]) continue;
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      tick();
      rd_en = 1'b0;
      e_rd  = m_mem[a];
      chk({tag, "_rd"}, rd_data, e_rd);
    end
    tick();
    chk({tag, "_rd_hold"}, rd_data, e_rd);
  endtask

  task automatic accept(input string tag);
    peak_ready = 1'b1;
    tick();
    peak_ready = 1'b0;
    chk({tag, "_acc_valid"}, peak_valid, 0);
    chk({tag, "_acc_busy"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; pwr_data = '0; pwr_data_en = 1'b0; pwr_data_last = 1'b0;
    peak_ready = 1'b0; rd_en = 1'b0; rd_addr = '0; e_rd = '0;
    for (int unsigned a = 0; a < CAP; a++) m_ok[a] = 0;
    tick(); tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: peak with tie, last on final beat
    frame_q = '{32'h3F800000, 32'h40800000, 32'h40000000, 32'h41100000,
                32'h41100000, 32'h3F000000, 32'h40400000, 32'h3F800000};
    send_frame(0, 0);
    check_result("t1");
    chk("t1_idx_lit", peak_index, 3);
    chk("t1_val_lit", peak_value, 32'h41100000);
    chk("t1_len_lit", frame_len, 8);
    accept("t1");

    // 2: delayed last, stalled ready with ignored beats, readback
    send_frame(7, 0);
    check_result("t2");
    for (int i = 0; i < 20; i++) begin
      pwr_data    = $urandom;
      pwr_data_en = 1'($urandom_range(0, 1));
      tick();
      chk("t2_hold_valid", peak_valid, 1);
      chk("t2_hold_idx", peak_index, e_idx);
      chk("t2_hold_val", peak_value, e_val);
      chk("t2_hold_len", frame_len, e_len);
      chk("t2_hold_ovf", frame_ovf, e_ovf);
    end
    pwr_data_en = 1'b0;
    readback_all("t2");
    accept("t2");
    rd_en = 1'b1; rd_addr = 3'd5;
    tick();
    rd_en = 1'b0;
    chk("rd_outside_hold", rd_data, e_rd);

    // 3: NaN stored but never peak
    frame_q = '{32'h3F800000, 32'h40000000, 32'h7FC00000, 32'h3F000000,
                32'h3FC00000, 32'h40400000, 32'h3F800000, 32'h40000000};
    send_frame(0, 1);
    check_result("t3");
    chk("t3_idx_lit", peak_index, 5);
    readback_all("t3");
    accept("t3");

    // 4: 11 beats into 8-bin capacity
    frame_q = {};
    for (int unsigned i = 0; i < 11; i++)
      frame_q.push_back((i == 3) ? 32'h42000000 : 32'h40000000 + i);
    send_frame(1, 0);
    check_result("t4");
    chk("t4_len_lit", frame_len, 8);
    chk("t4_ovf_lit", frame_ovf, 1);
    readback_all("t4");
    accept("t4");

    // 5: frame dropped in HOLD, then a fresh frame and an empty frame
    frame_q = '{32'h3F800000, 32'h40A00000, 32'h40000000};
    send_frame(0, 0);
    check_result("t5a");
    pwr_data = 32'h7F000000; pwr_data_en = 1'b1; pwr_data_last = 1'b1;
    tick();
    pwr_data_en = 1'b0; pwr_data_last = 1'b0;
    chk("t5_drop", frame_drop, 1);
    tick();
    chk("t5_drop_end", frame_drop, 0);
    chk("t5_idx_kept", peak_index, e_idx);
    accept("t5a");
    frame_q = '{32'h40400000, 32'h80000000, 32'hC1000000, 32'h41000000};
    send_frame(2, 0);
    check_result("t5b");
    chk("t5b_idx_lit", peak_index, 2);
    accept("t5b");
    frame_q = {};
    send_frame(0, 0);
    check_result("t5c");
    chk("t5c_val_lit", peak_value, 0);
    accept("t5c");

    // 6: reset mid-frame
    frame_q = '{32'h41F00000, 32'h41E00000, 32'h41D00000, 32'h41C00000};
    for (int unsigned i = 0; i < 4; i++) begin
      pwr_data = frame_q[i]; pwr_data_en = 1'b1;
      tick();
    end
    pwr_data_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6_rst");
    tick();
    check_zero_outputs("t6_rst2");
    rst_n = 1'b1;
    e_rd = '0;
    for (int unsigned a = 0; a < CAP; a++) m_ok[a] = 0;
    tick();
    frame_q = '{32'h3F800000, 32'h40000000, 32'h3F000000};
    send_frame(0, 0);
    check_result("t6");
    chk("t6_idx_lit", peak_index, 1);
    readback_all("t6");
    accept("t6");

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      int unsigned n = $urandom_range(0, 11);
      frame_q = {};
      for (int unsigned i = 0; i < n; i++) frame_q.push_back(rand_val());
      send_frame($urandom_range(0, 3), 1);
      check_result("rnd");
      readback_all("rnd");
      repeat ($urandom_range(0, 2)) tick();
      accept("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
